// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch time-keeping core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control and display bundle between the stopwatch core and its surroundings.
interface stopwatch_counter_if;

    logic       CLR;
    logic       PAUSE;
    logic       ADJ;
    logic       SEL;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       running;
    logic       blink;

    modport master (
        output CLR, PAUSE, ADJ, SEL,
        input  d0, d1, d2, d3, running, blink
    );

    modport slave (
        input  CLR, PAUSE, ADJ, SEL,
        output d0, d1, d2, d3, running, blink
    );

endinterface

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59; carry flags the 59 -> 00 rollover while inc is high.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry
);

    assign carry = inc && (ones == ONES_MAX) && (tens == TENS_MAX);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (clr) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc) begin
            if (ones == ONES_MAX) begin
                ones <= 4'd0;
                tens <= (tens == TENS_MAX) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: 1 Hz run tick, pause/run, clear and manual field adjust.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int ADJ_DIV  = 50000000,
    parameter int CNT_W    = 27
) (
    input  logic                CLK,
    input  logic                RESET_N,
    stopwatch_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ADJ_LAST  = CNT_W'(ADJ_DIV - 1);

    state_t           state;
    logic [CNT_W-1:0] divider;
    logic             run_tick;
    logic             adj_step;
    logic             sec_inc;
    logic             sec_carry;
    logic             min_inc;

    // CLR and ADJ both pre-empt the run tick; only a held ADJ produces adjust steps.
    assign run_tick = (state == RUN) && !bus.CLR && !bus.ADJ && (divider == TICK_LAST);
    assign adj_step = (state == ADJUST) && !bus.CLR && bus.ADJ && (divider == ADJ_LAST);
    assign sec_inc  = run_tick || (adj_step && !bus.SEL);
    assign min_inc  = (state == RUN) ? sec_carry : (adj_step && bus.SEL);

    bcd_mod60 u_seconds (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (sec_inc),
        .clr     (bus.CLR),
        .ones    (bus.d0),
        .tens    (bus.d1),
        .carry   (sec_carry)
    );

    bcd_mod60 u_minutes (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (min_inc),
        .clr     (bus.CLR),
        .ones    (bus.d2),
        .tens    (bus.d3),
        .carry   ()
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= PAUSED;
            divider     <= '0;
            bus.running <= 1'b0;
            bus.blink   <= 1'b0;
        end else if (bus.CLR) begin
            divider     <= '0;
            bus.running <= 1'b0;
            if (bus.ADJ) begin
                state <= ADJUST;
            end else begin
                state     <= PAUSED;
                bus.blink <= 1'b0;
            end
        end else if (bus.ADJ) begin
            bus.running <= 1'b0;
            if (state != ADJUST) begin
                state   <= ADJUST;
                divider <= '0;
            end else if (divider == ADJ_LAST) begin
                divider   <= '0;
                bus.blink <= ~bus.blink;
            end else begin
                divider <= divider + 1'b1;
            end
        end else begin
            case (state)
                ADJUST: begin
                    state       <= PAUSED;
                    divider     <= '0;
                    bus.blink   <= 1'b0;
                    bus.running <= 1'b0;
                end
                RUN: begin
                    // The divider keeps its phase across a pause so the second resumes where it stopped.
                    divider <= (divider == TICK_LAST) ? '0 : divider + 1'b1;
                    if (bus.PAUSE) begin
                        state       <= PAUSED;
                        bus.running <= 1'b0;
                    end else begin
                        bus.running <= 1'b1;
                    end
                end
                default: begin
                    if (bus.PAUSE) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                    end else begin
                        bus.running <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with a seconds-since-zero reference model.
module tb_stopwatch_counter;

    localparam int TICK_DIV = 4;
    localparam int ADJ_DIV  = 2;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    stopwatch_counter_if bus ();

    stopwatch_counter #(
        .TICK_DIV (TICK_DIV),
        .ADJ_DIV  (ADJ_DIV),
        .CNT_W    (27)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int compared = 0;
    int mismatched = 0;
    logic [17:0] expQ [$];

    // Model state: 0 paused, 1 run, 2 adjust.
    int   mState;
    int   mDiv;
    int   mSec;
    int   mMin;
    logic mBlink;

    function automatic logic [17:0] modelOut();
        return {4'(mMin / 10), 4'(mMin % 10), 4'(mSec / 10), 4'(mSec % 10), (mState == 1), mBlink};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.d3, bus.d2, bus.d1, bus.d0, bus.running, bus.blink};
    endfunction

    function automatic logic [17:0] packOut(int mm, int ss, logic run, logic blk);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, blk};
    endfunction

    task automatic checkOutput(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (mm:ss run blink)", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mDiv   = 0;
        mSec   = 0;
        mMin   = 0;
        mBlink = 1'b0;
    endtask

    task automatic modelStep(input logic clr, input logic pause, input logic adj, input logic sel);
        int t;
        if (clr) begin
            mSec = 0;
            mMin = 0;
            mDiv = 0;
            mState = adj ? 2 : 0;
            if (!adj) mBlink = 1'b0;
        end else if (adj) begin
            if (mState != 2) begin
                mState = 2;
                mDiv = 0;
            end else if (mDiv == ADJ_DIV - 1) begin
                mDiv = 0;
                if (sel) mMin = (mMin + 1) % 60;
                else     mSec = (mSec + 1) % 60;
                mBlink = ~mBlink;
            end else begin
                mDiv++;
            end
        end else if (mState == 2) begin
            mState = 0;
            mDiv = 0;
            mBlink = 1'b0;
        end else if (mState == 1) begin
            if (mDiv == TICK_DIV - 1) begin
                mDiv = 0;
                t = (mMin * 60 + mSec + 1) % 3600;
                mMin = t / 60;
                mSec = t % 60;
            end else begin
                mDiv++;
            end
            if (pause) mState = 0;
        end else if (pause) begin
            mState = 1;
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic pause, input logic adj, input logic sel);
        bus.CLR   = clr;
        bus.PAUSE = pause;
        bus.ADJ   = adj;
        bus.SEL   = sel;
        modelStep(clr, pause, adj, sel);
        expQ.push_back(modelOut());
        @(posedge CLK);
        #1;
        checkOutput("cycle", observed(), expQ.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic b0;
        int guard;
        bus.CLR = 1'b0;
        bus.PAUSE = 1'b0;
        bus.ADJ = 1'b0;
        bus.SEL = 1'b0;
        modelReset();

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset", observed(), 18'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(16);
        checkOutput("run16", observed(), packOut(0, 4, 1'b1, 1'b0));

        // Asynchronous reset asserted between clock edges.
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("async_reset", observed(), 18'h0);
        modelReset();
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 1 + 2 * 59; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkOutput("sec_carry", observed(), packOut(1, 0, 1'b1, 1'b0));

        for (int i = 0; i < 1 + 2 * 58; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2 * 59; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("preload_5959", observed(), packOut(59, 59, 1'b0, 1'b1));
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);
        checkOutput("wrap_0000", observed(), packOut(0, 0, 1'b1, 1'b0));

        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(20);
        checkOutput("frozen", observed(), packOut(0, 0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("resume_1", observed(), packOut(0, 0, 1'b1, 1'b0));
        idle(1);
        checkOutput("resume_2", observed(), packOut(0, 1, 1'b1, 1'b0));

        guard = 0;
        while (!(mState == 2 && mSec == 58 && mDiv == 0) && guard < 400) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 400) checkOutput("reach_0058", observed(), packOut(0, 58, 1'b0, mBlink));
        b0 = mBlink;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("adj_sec_wrap", observed(), packOut(0, 0, 1'b0, b0));
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("adj_min", observed(), packOut(1, 0, 1'b0, ~b0));

        guard = 0;
        while (mMin != 12 && guard < 200) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            guard++;
        end
        while (mSec != 34 && guard < 400) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_clr", observed(), packOut(12, 34, 1'b1, 1'b0));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("clr_pause", observed(), packOut(0, 0, 1'b0, 1'b0));
        idle(3);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("adj_pause_ignored", observed(), packOut(0, 1, 1'b0, 1'b1));
        idle(1);
        checkOutput("adj_exit", observed(), packOut(0, 1, 1'b0, 1'b0));

        // Mixed random control traffic against the model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
